pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, 32'h00000020, handler entry PC for all non-ERET exceptions.
REQ-002 SHALL have parameter WDT_LIMIT, 16'd1024, consecutive-stall cycles before watchdog trip.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stallreq_if  input  1  fetch-side bus wait.
REQ-006 SHALL have port stallreq_id  input  1  decode load-use hazard.
REQ-007 SHALL have port stallreq_ex  input  1  multi-cycle execute (div/madd) busy.
REQ-008 SHALL have port stallreq_mem  input  1  data-side bus wait.
REQ-009 SHALL have port excepttype  input  32  exception code from MEM stage; 0 = none.
REQ-010 SHALL have port cp0_epc  input  32  return address for ERET.
REQ-011 SHALL have port stall  output  6  stage hold vector: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
REQ-012 SHALL have port flush  output  1  pipeline-register flush pulse, registered.
REQ-013 SHALL have port new_pc  output  32  redirect target, valid only while flush=1, registered.
REQ-014 SHALL have port stall_timeout  output  1  sticky watchdog flag (WDT build only, else tied 0).

Function
REQ-015 SHALL run a 2-state FSM: RUN, FLUSH.
REQ-016 In RUN, a nonzero excepttype SHALL move the FSM to FLUSH next cycle with flush=1.
REQ-017 new_pc SHALL load cp0_epc when excepttype=32'h0000000e (ERET), else EXC_VECTOR, in the same edge that sets flush.
REQ-018 FLUSH SHALL last exactly one cycle, then return to RUN; flush and new_pc SHALL return to 0 in RUN.
REQ-019 excepttype SHALL be ignored while in FLUSH (back-to-back exceptions produce one flush pulse per RUN->FLUSH entry).
REQ-020 stall SHALL be combinational from stallreq_* and SHALL be 6'b000000 while in FLUSH or when excepttype is nonzero in RUN.
REQ-021 Stall priority, highest first: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
REQ-022 Simultaneous requests SHALL yield the highest-priority encoding only (no OR-merging).
REQ-023 stall[5] SHALL always be 0 (WB never held).

Reset
REQ-024 rst=1 SHALL force FSM=RUN, flush=0, new_pc=32'h0, watchdog counter=0, stall_timeout=0 on next posedge.
REQ-025 rst SHALL override any in-progress FLUSH or pending exception; stall SHALL be 6'b000000 while rst=1.

Configuration
REQ-026 Macro PIPE_CTRL_WDT_EN SHALL enable the stall watchdog; undefined removes counter and ties stall_timeout=0.
REQ-027 With PIPE_CTRL_WDT_EN: 16-bit counter SHALL increment each cycle stall[0]=1, clear when stall[0]=0 or flush=1, saturate at WDT_LIMIT.
REQ-028 With PIPE_CTRL_WDT_EN: stall_timeout SHALL set on the edge the counter reaches WDT_LIMIT and hold until rst.
REQ-029 Stall/flush/new_pc behaviour SHALL be identical with and without the macro.

Verification
REQ-030 Only stallreq_id=1 for 3 cycles -> stall=6'b000111 for those 3 cycles, then 6'b000000.
REQ-031 stallreq_if=1, stallreq_mem=1 together -> stall=6'b011111.
REQ-032 excepttype=32'h00000008 one cycle -> next cycle flush=1, new_pc=32'h00000020, stall=0; following cycle flush=0, new_pc=0.
REQ-033 excepttype=32'h0000000e, cp0_epc=32'h00001234 -> next cycle flush=1, new_pc=32'h00001234; exception held 2 cycles -> second cycle ignored, then re-flush on third only if still nonzero.
REQ-034 WDT build, WDT_LIMIT=4, stallreq_ex held 6 cycles -> stall_timeout=1 after 4th stalled edge, stays 1 after release until rst.
REQ-035 rst asserted during FLUSH cycle -> next cycle flush=0, new_pc=0, FSM=RUN, stall_timeout=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: stall requests and exception info in, hold/flush controls out.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;

    // Pipeline side: raises requests, obeys hold/flush
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype, cp0_epc,
        input  stall, flush, new_pc, stall_timeout
    );

    // Controller side
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype, cp0_epc,
        output stall, flush, new_pc, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller. Optional stall watchdog enabled by
// defining PIPE_CTRL_WDT_EN; without it stall_timeout is tied low.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [15:0] WDT_LIMIT  = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W    = 16;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [5:0]  stall_c;
    logic [5:0]  stall_enc;

    // Priority-encode stall requests; deepest requester wins, WB never held
    always_comb begin
        stall_enc = 6'b000000;
        if (bus.stallreq_mem)     stall_enc = 6'b011111;
        else if (bus.stallreq_ex) stall_enc = 6'b001111;
        else if (bus.stallreq_id) stall_enc = 6'b000111;
        else if (bus.stallreq_if) stall_enc = 6'b000011;
    end

    // Next state, registered-output next values, and combinational stall
    always_comb begin
        state_d  = state_q;
        flush_d  = 1'b0;
        new_pc_d = 32'h0;
        stall_c  = 6'b000000;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.excepttype != 32'h0) begin
                        state_d  = ST_FLUSH;
                        flush_d  = 1'b1;
                        new_pc_d = (bus.excepttype == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;
                    end else begin
                        stall_c = stall_enc;
                    end
                end
                ST_FLUSH: begin
                    // Exceptions are ignored here; one pulse per entry
                    state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State and registered flush/redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            new_pc_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign bus.stall  = stall_c;
    assign bus.flush  = flush_q;
    assign bus.new_pc = new_pc_q;

`ifdef PIPE_CTRL_WDT_EN
    logic [CNT_W-1:0] wdt_cnt_q;
    logic [CNT_W-1:0] wdt_cnt_d;
    logic             timeout_q;

    // Consecutive-stall count, saturating at the limit
    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        if (!stall_c[0] || flush_q) begin
            wdt_cnt_d = '0;
        end else if (wdt_cnt_q < WDT_LIMIT) begin
            wdt_cnt_d = wdt_cnt_q + CNT_W'(1);
        end
    end

    // Counter register and sticky trip flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            if (wdt_cnt_d == WDT_LIMIT && wdt_cnt_d != wdt_cnt_q) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.stall_timeout = timeout_q;
`else
    // Watchdog removed; limit parameter kept for a uniform interface
    logic unused_wdt;
    assign unused_wdt        = ^WDT_LIMIT;
    assign bus.stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl; WDT checks adapt to PIPE_CTRL_WDT_EN.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_WDT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    logic clk;
    logic rst;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .WDT_LIMIT  (16'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        sif;
        logic        sid;
        logic        sex;
        logic        smem;
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic sif, input logic sid,
                                input logic sex, input logic smem,
                                input logic [31:0] exc, input logic [31:0] epc,
                                input logic [5:0] st, input logic fl, input logic [31:0] pc);
        vec_t v;
        v.r = r; v.sif = sif; v.sid = sid; v.sex = sex; v.smem = smem;
        v.exc = exc; v.epc = epc; v.st = st; v.fl = fl; v.pc = pc;
        return v;
    endfunction

    task automatic drive(input logic r, input logic sif, input logic sid, input logic sex,
                         input logic smem, input logic [31:0] exc, input logic [31:0] epc);
        rst              = r;
        bus.stallreq_if  = sif;
        bus.stallreq_id  = sid;
        bus.stallreq_ex  = sex;
        bus.stallreq_mem = smem;
        bus.excepttype   = exc;
        bus.cp0_epc      = epc;
    endtask

    initial begin
        // Each row: inputs for this cycle, outputs expected in this cycle
        // (stall from current inputs, flush/new_pc from the previous cycle).
        vecs[0]  = mk(0, 0,1,0,0, 32'h0,        32'h0,    6'b000111, 0, 32'h0);
        vecs[1]  = mk(0, 0,1,0,0, 32'h0,        32'h0,    6'b000111, 0, 32'h0);
        vecs[2]  = mk(0, 0,1,0,0, 32'h0,        32'h0,    6'b000111, 0, 32'h0);
        vecs[3]  = mk(0, 0,0,0,0, 32'h0,        32'h0,    6'b000000, 0, 32'h0);
        vecs[4]  = mk(0, 1,0,0,1, 32'h0,        32'h0,    6'b011111, 0, 32'h0);
        vecs[5]  = mk(0, 0,0,1,0, 32'h0,        32'h0,    6'b001111, 0, 32'h0);
        vecs[6]  = mk(0, 1,0,0,0, 32'h0,        32'h0,    6'b000011, 0, 32'h0);
        vecs[7]  = mk(0, 0,0,0,0, 32'h0,        32'h0,    6'b000000, 0, 32'h0);
        vecs[8]  = mk(0, 0,1,1,0, 32'h0,        32'h0,    6'b001111, 0, 32'h0);
        vecs[9]  = mk(0, 1,1,1,1, 32'h0,        32'h0,    6'b011111, 0, 32'h0);
        vecs[10] = mk(0, 0,0,0,0, 32'h0,        32'h0,    6'b000000, 0, 32'h0);
        vecs[11] = mk(0, 0,0,0,1, 32'h8,        32'h0,    6'b000000, 0, 32'h0);
        vecs[12] = mk(0, 0,0,0,1, 32'h0,        32'h0,    6'b000000, 1, 32'h20);
        vecs[13] = mk(0, 0,0,0,1, 32'h0,        32'h0,    6'b011111, 0, 32'h0);
        vecs[14] = mk(0, 0,0,0,0, 32'he,        32'h1234, 6'b000000, 0, 32'h0);
        vecs[15] = mk(0, 0,0,0,0, 32'he,        32'h1234, 6'b000000, 1, 32'h1234);
        vecs[16] = mk(0, 0,0,0,0, 32'he,        32'h1234, 6'b000000, 0, 32'h0);
        vecs[17] = mk(0, 0,0,0,0, 32'h0,        32'h1234, 6'b000000, 1, 32'h1234);
        vecs[18] = mk(0, 0,0,0,0, 32'h0,        32'h0,    6'b000000, 0, 32'h0);
        vecs[19] = mk(0, 0,0,0,0, 32'h80000000, 32'h1234, 6'b000000, 0, 32'h0);
        vecs[20] = mk(0, 0,0,0,0, 32'h0,        32'h0,    6'b000000, 1, 32'h20);
        vecs[21] = mk(0, 0,0,0,0, 32'h8,        32'h0,    6'b000000, 0, 32'h0);
        vecs[22] = mk(1, 0,0,0,1, 32'h0,        32'h0,    6'b000000, 1, 32'h20);
        vecs[23] = mk(0, 0,1,0,0, 32'h0,        32'h0,    6'b000111, 0, 32'h0);
        vecs[24] = mk(1, 0,0,0,1, 32'h8,        32'h0,    6'b000000, 0, 32'h0);
        vecs[25] = mk(0, 0,0,0,0, 32'h0,        32'h0,    6'b000000, 0, 32'h0);
        vecs[26] = mk(0, 0,0,1,0, 32'h0,        32'h0,    6'b001111, 0, 32'h0);
        vecs[27] = mk(0, 0,0,0,0, 32'h0,        32'h0,    6'b000000, 0, 32'h0);

        // Reset with stall requests and a pending exception present
        drive(1, 0,0,0,0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1, 1,1,1,1, 32'h8, 32'h1234);
        #1;
        chk("rst_stall_comb", 32'(bus.stall), 32'h0);
        @(negedge clk);
        #1;
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_new_pc", bus.new_pc, 32'h0);
        chk("rst_timeout", 32'(bus.stall_timeout), 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].r, vecs[i].sif, vecs[i].sid, vecs[i].sex, vecs[i].smem,
                  vecs[i].exc, vecs[i].epc);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].st));
            chk($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(vecs[i].fl));
            chk($sformatf("v%0d_new_pc", i), bus.new_pc, vecs[i].pc);
            chk($sformatf("v%0d_timeout", i), 32'(bus.stall_timeout), 32'h0);
        end

        // Watchdog: execute busy for 6 cycles, limit 4
        @(negedge clk);
        drive(1, 0,0,0,0, 32'h0, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            drive(0, 0,0,1,0, 32'h0, 32'h0);
            #1;
            // k-1 stalled edges have elapsed here
            chk($sformatf("wdt_hold%0d", k), 32'(bus.stall_timeout),
                32'((WDT && (k - 1) >= 4) ? 1 : 0));
            chk($sformatf("wdt_stall%0d", k), 32'(bus.stall), 32'b001111);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 0,0,0,0, 32'h0, 32'h0);
            #1;
            chk($sformatf("wdt_sticky%0d", k), 32'(bus.stall_timeout), 32'(WDT ? 1 : 0));
        end
        @(negedge clk);
        drive(1, 0,0,0,0, 32'h0, 32'h0);
        @(negedge clk);
        drive(0, 0,0,0,0, 32'h0, 32'h0);
        #1;
        chk("wdt_rst_clear", 32'(bus.stall_timeout), 32'h0);

        // Watchdog must not trip on a run shorter than the limit
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive(0, 0,0,0,(k < 4), 32'h0, 32'h0);
            #1;
            chk($sformatf("wdt_short%0d", k), 32'(bus.stall_timeout), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
